prog_delay_line: RTL and testbench



---
 rtl/prog_delay_line_pkg.sv | 17 +
 rtl/prog_delay_line_if.sv | 33 +++
 rtl/prog_delay_line_ring_mem.sv | 23 ++
 rtl/prog_delay_line.sv | 107 ++++++++++
 tb/tb_prog_delay_line.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/prog_delay_line_pkg.sv
// Shared constants and width helper for the programmable sample delay line.
package delay_line_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Depths of the fixed delay lines this block replaces.
  localparam int LEGACY_DEPTH_30 = 30;
  localparam int LEGACY_DEPTH_45 = 45;
  localparam int LEGACY_DEPTH_60 = 60;
  localparam int LEGACY_DEPTH_90 = 90;

  // Bits needed to hold any value in 0..max_depth.
  function automatic int dw_of(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Sample stream, delay control and status bundle for prog_delay_line.
interface prog_delay_line_if
  import delay_line_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_DEPTH = LEGACY_DEPTH_90,
  parameter int DW        = dw_of(MAX_DEPTH)
);
  // Valid-only stream, no backpressure: a sample is taken on every rising
  // edge where in_valid is high and flush is low; out_valid marks the one
  // cycle in which out_data carries a delayed sample.
  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic             delay_load;
  logic [DW-1:0]    delay_sel;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DW-1:0]    delay_q;
  logic [DW-1:0]    fill_level;
  logic             delay_err;

  modport master (
    output in_valid, data_in, delay_load, delay_sel, flush,
    input  out_valid, out_data, delay_q, fill_level, delay_err
  );

  modport slave (
    input  in_valid, data_in, delay_load, delay_sel, flush,
    output out_valid, out_data, delay_q, fill_level, delay_err
  );

endinterface

// File: rtl/prog_delay_line_ring_mem.sv
// Circular sample store: synchronous write, asynchronous indexed read, no reset.
module delay_ring_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 90,
  parameter int AW    = 7
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable sample delay over a circular buffer; ages data only
// on accepted samples and suppresses output until enough history exists.
module prog_delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int MAX_DEPTH     = LEGACY_DEPTH_90,
  parameter int DEFAULT_DELAY = LEGACY_DEPTH_30
) (
  input logic               clock,
  input logic               reset,
  prog_delay_line_if.slave  bus
);

  localparam int DW = dw_of(MAX_DEPTH);
  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DEF_D  = DW'(DEFAULT_DELAY);
  localparam logic [DW-1:0] ONE_D  = DW'(1);
  localparam logic [DW-1:0] ZERO_D = '0;

  logic [DW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             accept;
  logic [DW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;

  delay_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .we_i    (accept & ~reset),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.data_in),
    .raddr_i (rd_idx[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    accept = bus.in_valid & ~bus.flush;

    // Modular subtract without a divider; D == MAX_DEPTH lands on wr_ptr,
    // which still holds the oldest sample because the read precedes the write.
    if (wr_ptr_q >= dly_q) rd_idx = wr_ptr_q - dly_q;
    else                   rd_idx = wr_ptr_q + MAX_D - dly_q;

    dly_d = dly_q;
    err_d = err_q;
    if (bus.delay_load) begin
      if (bus.delay_sel > MAX_D) begin
        dly_d = MAX_D;
        err_d = 1'b1;
      end else begin
        dly_d = bus.delay_sel;
      end
    end

    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (accept) begin
      wr_ptr_d = (wr_ptr_q == MAX_D - ONE_D) ? ZERO_D : wr_ptr_q + ONE_D;
      if (fill_q != MAX_D) fill_d = fill_q + ONE_D;
      // Accept uses the delay in force before any same-cycle load.
      if (fill_q >= dly_q) begin
        out_valid_d = 1'b1;
        out_data_d  = (dly_q == ZERO_D) ? bus.data_in : rd_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      dly_q       <= DEF_D;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.delay_q    = dly_q;
  assign bus.fill_level = fill_q;
  assign bus.delay_err  = err_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: streamed loops plus a vector table.
module tb_prog_delay_line;
  import delay_line_pkg::*;

  localparam int WIDTH = 8;
  localparam int MAXD  = 90;
  localparam int DEFD  = 30;
  localparam int DW    = dw_of(MAXD);

  logic clock;
  logic reset;

  prog_delay_line_if #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .DW(DW)) bus ();

  prog_delay_line #(
    .WIDTH         (WIDTH),
    .MAX_DEPTH     (MAXD),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ld;
    logic [DW-1:0]    sel;
    logic             fl;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic [DW-1:0]    edly;
    logic [DW-1:0]    efill;
    logic             eerr;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs, clock once, settle past the edge
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ld,
                      input logic [DW-1:0] sel, input logic fl);
    bus.in_valid   = iv;
    bus.data_in    = d;
    bus.delay_load = ld;
    bus.delay_sel  = sel;
    bus.flush      = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int ev, input int ed, input int edly,
                           input int efill, input int eerr);
    check({tag, ".valid"}, int'(bus.out_valid), ev);
    check({tag, ".data"},  int'(bus.out_data), ed);
    check({tag, ".delay"}, int'(bus.delay_q), edly);
    check({tag, ".fill"},  int'(bus.fill_level), efill);
    check({tag, ".err"},   int'(bus.delay_err), eerr);
  endtask

  int exp_data;
  int exp_v;

  initial begin
    reset = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    check_all("reset", 0, 0, DEFD, 0, 0);
    reset = 1'b0;

    // default D=30, samples 1,2,3,... back-to-back
    exp_data = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1'b1, WIDTH'(k), 1'b0, '0, 1'b0);
      exp_v = (k >= DEFD + 1) ? 1 : 0;
      if (exp_v == 1) exp_data = k - DEFD;
      check_all("d30", exp_v, exp_data, DEFD, k, 0);
    end

    // raise D to 45 on an idle cycle; fill 50 already covers it
    step(1'b0, '0, 1'b1, DW'(45), 1'b0);
    check_all("ld45", 0, exp_data, 45, 50, 0);
    for (int k = 51; k <= 55; k++) begin
      step(1'b1, WIDTH'(k), 1'b0, '0, 1'b0);
      exp_data = k - 45;
      check_all("d45", 1, exp_data, 45, (k > MAXD) ? MAXD : k, 0);
    end

    // flush together with a load of D=90; the load still takes effect
    step(1'b0, '0, 1'b1, DW'(MAXD), 1'b1);
    check_all("flush_ld90", 0, exp_data, MAXD, 0, 0);
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, WIDTH'(k), 1'b0, '0, 1'b0);
      exp_v = (k >= MAXD + 1) ? 1 : 0;
      if (exp_v == 1) exp_data = k - MAXD;
      check_all("d90", exp_v, exp_data, MAXD, (k > MAXD) ? MAXD : k, 0);
    end

    // vector table: D=0, same-cycle load/accept, D=4 gapped stream, delay_err
    //            iv    d      ld    sel       fl    ev    ed     edly    efill  eerr
    vecs[0]  = '{1'b0, 8'h00, 1'b1, DW'(0),   1'b1, 1'b0, 8'd110, DW'(0),  DW'(0), 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, DW'(0),   1'b0, 1'b1, 8'hA5, DW'(0),  DW'(1), 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, DW'(0),   1'b0, 1'b0, 8'hA5, DW'(0),  DW'(1), 1'b0};
    vecs[3]  = '{1'b1, 8'h5A, 1'b1, DW'(4),   1'b0, 1'b1, 8'h5A, DW'(4),  DW'(2), 1'b0};
    vecs[4]  = '{1'b1, 8'hFF, 1'b0, DW'(0),   1'b1, 1'b0, 8'h5A, DW'(4),  DW'(0), 1'b0};
    vecs[5]  = '{1'b1, 8'd10, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(1), 1'b0};
    vecs[6]  = '{1'b0, 8'd99, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(1), 1'b0};
    vecs[7]  = '{1'b0, 8'd99, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(1), 1'b0};
    vecs[8]  = '{1'b1, 8'd11, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(2), 1'b0};
    vecs[9]  = '{1'b1, 8'd12, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(3), 1'b0};
    vecs[10] = '{1'b0, 8'd99, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(3), 1'b0};
    vecs[11] = '{1'b1, 8'd13, 1'b0, DW'(0),   1'b0, 1'b0, 8'h5A, DW'(4),  DW'(4), 1'b0};
    vecs[12] = '{1'b1, 8'd14, 1'b0, DW'(0),   1'b0, 1'b1, 8'd10, DW'(4),  DW'(5), 1'b0};
    vecs[13] = '{1'b0, 8'd99, 1'b0, DW'(0),   1'b0, 1'b0, 8'd10, DW'(4),  DW'(5), 1'b0};
    vecs[14] = '{1'b0, 8'd00, 1'b1, DW'(100), 1'b0, 1'b0, 8'd10, DW'(90), DW'(5), 1'b1};
    vecs[15] = '{1'b0, 8'd00, 1'b0, DW'(0),   1'b0, 1'b0, 8'd10, DW'(90), DW'(5), 1'b1};
    vecs[16] = '{1'b1, 8'd20, 1'b0, DW'(0),   1'b0, 1'b0, 8'd10, DW'(90), DW'(6), 1'b1};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ld, vecs[i].sel, vecs[i].fl);
      check_all($sformatf("vec%0d", i), int'(vecs[i].ev), int'(vecs[i].ed),
                int'(vecs[i].edly), int'(vecs[i].efill), int'(vecs[i].eerr));
    end

    // reset mid-stream wins over accept and load in the same cycle
    for (int k = 21; k <= 24; k++) step(1'b1, WIDTH'(k), 1'b0, '0, 1'b0);
    check("pre_rst.fill", int'(bus.fill_level), 10);
    reset = 1'b1;
    step(1'b1, 8'h77, 1'b1, DW'(7), 1'b0);
    check_all("mid_rst", 0, 0, DEFD, 0, 0);
    reset = 1'b0;
    step(1'b1, 8'h01, 1'b0, '0, 1'b0);
    check_all("post_rst", 0, 0, DEFD, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
